// File: rtl/gf_pkg.sv
// GF(2^SYMB_WIDTH) field constants and constant-time helpers shared by the RS encoder/decoder chain.
// Field is built on the primitive polynomial PRIM_POLY with alpha = x (0x2).
package gf_pkg;
    localparam int SYMB_WIDTH = 4;
    localparam int T_LEN      = 2;
    localparam int SYMB_NUM   = 1 << SYMB_WIDTH;
    localparam logic [SYMB_WIDTH:0] PRIM_POLY = 5'h13;

    typedef logic [2*T_LEN-1:0][SYMB_WIDTH-1:0] gen_t;

    function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                      input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] r;
        logic [SYMB_WIDTH-1:0] aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[SYMB_WIDTH-2:0], 1'b0} ^ (aa[SYMB_WIDTH-1] ? PRIM_POLY[SYMB_WIDTH-1:0] : '0);
        end
        return r;
    endfunction

    // g(x) = prod (x + alpha^i), i = 0..2*T_LEN-1; the monic top coefficient is dropped.
    function automatic gen_t gen_poly();
        logic [2*T_LEN:0][SYMB_WIDTH-1:0] c;
        logic [SYMB_WIDTH-1:0]            root;
        c    = '0;
        c[0] = SYMB_WIDTH'(1);
        root = SYMB_WIDTH'(1);
        for (int i = 0; i < 2*T_LEN; i++) begin
            for (int j = 2*T_LEN; j > 0; j--)
                c[j] = c[j-1] ^ gf_mult(c[j], root);
            c[0] = gf_mult(c[0], root);
            root = gf_mult(root, SYMB_WIDTH'(2));
        end
        return c[2*T_LEN-1:0];
    endfunction
endpackage

// File: rtl/rs_enc_stream.sv
// Systematic RS encoder: forwards K_LEN message symbols, then appends 2*T_LEN LFSR parity symbols.
// Latency: one cycle from input handshake to registered output; one symbol per cycle sustained.
// Backpressure: output register, LFSR and counters hold while data_vld_o && !data_rdy_i.
module rs_enc_stream #(
    parameter int K_LEN = gf_pkg::SYMB_NUM - 1 - 2*gf_pkg::T_LEN
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [gf_pkg::SYMB_WIDTH-1:0] data_i,
    input  logic                          data_vld_i,
    input  logic                          data_last_i,
    output logic                          data_rdy_o,
    output logic [gf_pkg::SYMB_WIDTH-1:0] data_o,
    output logic                          data_vld_o,
    output logic                          data_last_o,
    input  logic                          data_rdy_i,
    output logic                          enc_err_o
);
    import gf_pkg::*;

    localparam int SW   = SYMB_WIDTH;
    localparam int NPAR = 2*T_LEN;
    localparam int MW   = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam int PW   = $clog2(NPAR);
    localparam logic [MW-1:0] MSG_LAST = MW'(K_LEN-1);
    localparam logic [PW-1:0] PAR_LAST = PW'(NPAR-1);
    localparam gen_t G = gen_poly();

    localparam logic PH_MSG = 1'b0;
    localparam logic PH_PAR = 1'b1;

    logic                       phase;
    logic [MW-1:0]              msg_cnt;
    logic [PW-1:0]              par_cnt;
    logic [NPAR-1:0][SW-1:0]    p;
    logic [NPAR-1:0][SW-1:0]    p_nxt;
    logic [SW-1:0]              fb;
    logic                       adv;
    logic                       in_hs;
    logic                       msg_last;
    logic                       par_last;

    assign adv        = !data_vld_o || data_rdy_i;
    assign data_rdy_o = (phase == PH_MSG) && adv;
    assign in_hs      = data_vld_i && data_rdy_o;
    assign msg_last   = (msg_cnt == MSG_LAST);
    assign par_last   = (par_cnt == PAR_LAST);
    assign fb         = data_i ^ p[NPAR-1];

    // Message phase divides by g(x); parity phase just shifts the remainder out with zero feed.
    always_comb begin
        p_nxt = p;
        if (phase == PH_MSG) begin
            p_nxt[0] = gf_mult(fb, G[0]);
            for (int j = 1; j < NPAR; j++)
                p_nxt[j] = p[j-1] ^ gf_mult(fb, G[j]);
        end else begin
            p_nxt[0] = '0;
            for (int j = 1; j < NPAR; j++)
                p_nxt[j] = p[j-1];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase       <= PH_MSG;
            msg_cnt     <= '0;
            par_cnt     <= '0;
            p           <= '0;
            data_o      <= '0;
            data_vld_o  <= 1'b0;
            data_last_o <= 1'b0;
            enc_err_o   <= 1'b0;
        end else begin
            // The internal count is authoritative; a disagreeing last flag is only reported.
            enc_err_o <= in_hs && (data_last_i != msg_last);
            if (adv) begin
                if (phase == PH_MSG) begin
                    data_last_o <= 1'b0;
                    if (data_vld_i) begin
                        data_o     <= data_i;
                        data_vld_o <= 1'b1;
                        p          <= p_nxt;
                        if (msg_last) begin
                            msg_cnt <= '0;
                            phase   <= PH_PAR;
                        end else begin
                            msg_cnt <= msg_cnt + MW'(1);
                        end
                    end else begin
                        data_vld_o <= 1'b0;
                    end
                end else begin
                    data_o      <= p[NPAR-1];
                    data_vld_o  <= 1'b1;
                    data_last_o <= par_last;
                    p           <= p_nxt;
                    if (par_last) begin
                        par_cnt <= '0;
                        phase   <= PH_MSG;
                    end else begin
                        par_cnt <= par_cnt + PW'(1);
                    end
                end
            end
        end
    end
endmodule
